image_window_gen: RTL and testbench



---
 rtl/image_pkg.sv | 15 +
 rtl/line_buffer.sv | 25 ++
 rtl/image_window_gen.sv | 148 ++++++++++++++
 tb/tb_image_window_gen.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared pixel/window types and 3x3 window indexing for the image path
package image_pkg;

    localparam int DATA_BW    = 10;
    localparam int WIN_DIM    = 3;
    localparam int WIN_CENTRE = 4;

    typedef logic [DATA_BW-1:0] pixel_t;
    typedef pixel_t window_t [WIN_DIM*WIN_DIM];

    function automatic int win_idx(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port row store, combinational read-before-write, registered write
module line_buffer #(
    parameter int p_data_bw = 10,
    parameter int p_depth   = 640,
    localparam int ADDR_BW  = $clog2(p_depth)
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_BW-1:0]   i_addr,
    input  logic [p_data_bw-1:0] i_wdata,
    output logic [p_data_bw-1:0] o_rdata
);

    // Contents are never reset; the caller suppresses output until both rows are valid.
    logic [p_data_bw-1:0] r_mem [p_depth];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/image_window_gen.sv
// rtl/image_window_gen.sv - raster pixel stream to 3x3 neighbourhood stream for interior pixels
module image_window_gen
    import image_pkg::*;
#(
    parameter int p_data_bw    = 10,
    parameter int p_win_size   = 9,
    parameter int p_img_width  = 640,
    parameter int p_img_height = 480
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_dxi_in_valid,
    output logic                 o_dxi_in_ready,
    input  logic [p_data_bw-1:0] i_dxi_in_data,
    output logic                 o_dxi_out_valid,
    input  logic                 i_dxi_out_ready,
    output logic [p_data_bw-1:0] o_dxi_out_data [p_win_size],
    output logic                 o_dxi_out_last
);

    localparam int COL_BW = $clog2(p_img_width);
    localparam int ROW_BW = $clog2(p_img_height);
    localparam logic [COL_BW-1:0] COL_LAST = COL_BW'(p_img_width - 1);
    localparam logic [ROW_BW-1:0] ROW_LAST = ROW_BW'(p_img_height - 1);
    localparam logic [COL_BW-1:0] COL_MIN  = COL_BW'(2);
    localparam logic [ROW_BW-1:0] ROW_MIN  = ROW_BW'(2);

    if (p_win_size != WIN_DIM * WIN_DIM) begin : g_bad_win_size
        $error("image_window_gen: p_win_size must be 9");
    end
    if (p_img_width < 3 || p_img_height < 3) begin : g_bad_img_size
        $error("image_window_gen: image must be at least 3x3");
    end

    logic [COL_BW-1:0]    r_col;
    logic [ROW_BW-1:0]    r_row;
    logic [p_data_bw-1:0] r_top_hist [2];
    logic [p_data_bw-1:0] r_mid_hist [2];
    logic [p_data_bw-1:0] r_new_hist [2];
    logic [p_data_bw-1:0] r_out_data [p_win_size];
    logic                 r_out_valid;
    logic                 r_out_last;

    logic                 w_accept;
    logic                 w_emit;
    logic                 w_frame_end;
    logic [p_data_bw-1:0] w_top;
    logic [p_data_bw-1:0] w_mid;
    logic [p_data_bw-1:0] w_win [p_win_size];

    assign o_dxi_in_ready = !r_out_valid || i_dxi_out_ready;
    assign w_accept       = i_dxi_in_valid && o_dxi_in_ready;
    assign w_emit         = (r_row >= ROW_MIN) && (r_col >= COL_MIN);
    assign w_frame_end    = (r_row == ROW_LAST) && (r_col == COL_LAST);

    // lb0 holds the previous row, lb1 the row before that; lb1 is refilled from lb0 as lb0 is overwritten.
    line_buffer #(
        .p_data_bw (p_data_bw),
        .p_depth   (p_img_width)
    ) u_lb0 (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (i_dxi_in_data),
        .o_rdata (w_mid)
    );

    line_buffer #(
        .p_data_bw (p_data_bw),
        .p_depth   (p_img_width)
    ) u_lb1 (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_mid),
        .o_rdata (w_top)
    );

    // Two columns of history plus the live column form the window of the pixel being accepted.
    always_comb begin
        for (int k = 0; k < p_win_size; k++) begin
            w_win[k] = '0;
        end
        w_win[win_idx(0, 0)] = r_top_hist[0];
        w_win[win_idx(0, 1)] = r_top_hist[1];
        w_win[win_idx(0, 2)] = w_top;
        w_win[win_idx(1, 0)] = r_mid_hist[0];
        w_win[win_idx(1, 1)] = r_mid_hist[1];
        w_win[win_idx(1, 2)] = w_mid;
        w_win[win_idx(2, 0)] = r_new_hist[0];
        w_win[win_idx(2, 1)] = r_new_hist[1];
        w_win[win_idx(2, 2)] = i_dxi_in_data;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // History shifts across row boundaries too; stale columns are masked by the c>=2 rule.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < 2; k++) begin
                r_top_hist[k] <= '0;
                r_mid_hist[k] <= '0;
                r_new_hist[k] <= '0;
            end
        end else if (w_accept) begin
            r_top_hist[0] <= r_top_hist[1];
            r_mid_hist[0] <= r_mid_hist[1];
            r_new_hist[0] <= r_new_hist[1];
            r_top_hist[1] <= w_top;
            r_mid_hist[1] <= w_mid;
            r_new_hist[1] <= i_dxi_in_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int k = 0; k < p_win_size; k++) begin
                r_out_data[k] <= '0;
            end
        end else if (w_accept && w_emit) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_frame_end;
            r_out_data  <= w_win;
        end else if (r_out_valid && i_dxi_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign o_dxi_out_valid = r_out_valid;
    assign o_dxi_out_last  = r_out_last;
    assign o_dxi_out_data  = r_out_data;

endmodule

// File: tb/tb_image_window_gen.sv
// tb/tb_image_window_gen.sv - scoreboard bench for image_window_gen on a 4x4 image
module tb_image_window_gen;
    import image_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic [9:0] d [9];
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       out_valid;
    logic       out_ready;
    pixel_t     out_data [9];
    logic       out_last;

    int   total = 0;
    int   bad = 0;
    int   win_cnt = 0;
    int   last_cnt = 0;
    int   acc_cnt = 0;
    int   m_row = 0;
    int   m_col = 0;
    bit   rnd_ready = 0;
    logic [9:0] img [H][W];
    exp_t sb [$];
    exp_t mon_ex;
    bit   mon_mis;

    int first_off [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int last_off  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    int p11_off   [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int p14_off   [9] = '{4, 5, 6, 8, 9, 10, 12, 13, 14};

    always #5 clk = ~clk;

    image_window_gen #(
        .p_data_bw    (10),
        .p_win_size   (9),
        .p_img_width  (W),
        .p_img_height (H)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_dxi_in_valid  (in_valid),
        .o_dxi_in_ready  (in_ready),
        .i_dxi_in_data   (in_data),
        .o_dxi_out_valid (out_valid),
        .i_dxi_out_ready (out_ready),
        .o_dxi_out_data  (out_data),
        .o_dxi_out_last  (out_last)
    );

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Reference model: a plain image array, expected windows pushed on input accept.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got window %p last=%0b, required no window", out_data, out_last);
                end else begin
                    mon_ex = sb.pop_front();
                    mon_mis = (out_last !== mon_ex.last);
                    for (int k = 0; k < 9; k++) begin
                        if (out_data[k] !== mon_ex.d[k]) mon_mis = 1;
                    end
                    if (mon_mis) begin
                        bad++;
                        $display("FAIL sb_window: got %p last=%0b, required %p last=%0b", out_data, out_last, mon_ex.d, mon_ex.last);
                    end
                end
                win_cnt++;
                if (out_last) last_cnt++;
            end
            if (in_valid && in_ready) begin
                img[m_row][m_col] = in_data;
                acc_cnt++;
                if (m_row >= 2 && m_col >= 2) begin
                    for (int k = 0; k < 9; k++) begin
                        mon_ex.d[k] = img[m_row - 2 + k / 3][m_col - 2 + k % 3];
                    end
                    mon_ex.last = (m_row == H - 1) && (m_col == W - 1);
                    sb.push_back(mon_ex);
                end
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic do_reset();
        in_valid  = 0;
        in_data   = '0;
        out_ready = 1;
        rstn      = 0;
        repeat (3) @(posedge clk);
        #1;
        m_row = 0;
        m_col = 0;
        sb.delete();
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input int v);
        bit done;
        int n;
        done = 0;
        n = 0;
        in_valid = 1;
        in_data  = 10'(v);
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got no accept of pixel %0d in %0d cycles, required accept", v, n);
                done = 1;
            end
        end
    endtask

    task automatic settle();
        rnd_ready = 0;
        in_valid  = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            out_ready = 1;
        end
    endtask

    task automatic stream_frame(input int base, input bit rnd);
        int r, c, gap;
        bit mis;
        for (int p = 0; p < W * H; p++) begin
            if (rnd) begin
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    in_valid = 0;
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            drive_pixel(base + p);
            r = p / W;
            c = p % W;
            total++;
            if (out_valid !== ((r >= 2) && (c >= 2))) begin
                bad++;
                $display("FAIL latency_valid: got valid=%0b after pixel %0d, required %0b", out_valid, base + p, (r >= 2) && (c >= 2));
            end
            if (p == 10) begin
                mis = (out_last !== 1'b0);
                for (int k = 0; k < 9; k++) if (out_data[k] !== 10'(base + first_off[k])) mis = 1;
                total++;
                if (mis) begin
                    bad++;
                    $display("FAIL first_window: got %p last=%0b, required base %0d + %p last=0", out_data, out_last, base, first_off);
                end
            end
            if (p == 15) begin
                mis = (out_last !== 1'b1);
                for (int k = 0; k < 9; k++) if (out_data[k] !== 10'(base + last_off[k])) mis = 1;
                total++;
                if (mis) begin
                    bad++;
                    $display("FAIL final_window: got %p last=%0b, required base %0d + %p last=1", out_data, out_last, base, last_off);
                end
            end
        end
    endtask

    task automatic check_drained(input string name, input int win0, input int nwin, input int last0, input int nlast);
        total++;
        if (sb.size() != 0 || (win_cnt - win0) != nwin || (last_cnt - last0) != nlast) begin
            bad++;
            $display("FAIL %s_count: got windows=%0d lasts=%0d pending=%0d, required windows=%0d lasts=%0d pending=0",
                     name, win_cnt - win0, last_cnt - last0, sb.size(), nwin, nlast);
        end
    endtask

    task automatic test_reset();
        bit mis;
        do_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mis = 0;
        for (int k = 0; k < 9; k++) if (out_data[k] !== '0) mis = 1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || mis) begin
            bad++;
            $display("FAIL reset_state: got valid=%0b ready=%0b last=%0b data=%p, required 0 1 0 zeros", out_valid, in_ready, out_last, out_data);
        end
    endtask

    task automatic test_stream();
        int w0, l0;
        do_reset();
        w0 = win_cnt;
        l0 = last_cnt;
        stream_frame(0, 0);
        settle();
        check_drained("stream", w0, 4, l0, 1);
    endtask

    task automatic test_stall();
        int w0, l0, a0;
        bit mis;
        do_reset();
        w0 = win_cnt;
        l0 = last_cnt;
        for (int p = 0; p < 12; p++) drive_pixel(p);
        out_ready = 0;
        in_data   = 10'd12;
        a0 = acc_cnt;
        repeat (5) begin
            @(posedge clk);
            #1;
            mis = (out_valid !== 1'b1) || (out_last !== 1'b0);
            for (int k = 0; k < 9; k++) if (out_data[k] !== 10'(p11_off[k])) mis = 1;
            total++;
            if (mis || in_ready !== 1'b0 || acc_cnt != a0) begin
                bad++;
                $display("FAIL stall_hold: got valid=%0b ready=%0b accepts=%0d data=%p, required 1 0 %0d %p",
                         out_valid, in_ready, acc_cnt, out_data, a0, p11_off);
            end
        end
        out_ready = 1;
        for (int p = 12; p < 16; p++) begin
            drive_pixel(p);
            if (p == 14) begin
                mis = (out_valid !== 1'b1);
                for (int k = 0; k < 9; k++) if (out_data[k] !== 10'(p14_off[k])) mis = 1;
                total++;
                if (mis) begin
                    bad++;
                    $display("FAIL stall_resume: got valid=%0b data=%p, required 1 %p", out_valid, out_data, p14_off);
                end
            end
        end
        settle();
        check_drained("stall", w0, 4, l0, 1);
    endtask

    task automatic test_back_to_back();
        int w0, l0;
        do_reset();
        w0 = win_cnt;
        l0 = last_cnt;
        stream_frame(0, 0);
        stream_frame(100, 0);
        settle();
        check_drained("back_to_back", w0, 8, l0, 2);
    endtask

    task automatic test_reset_mid_frame();
        int w0, l0;
        do_reset();
        for (int p = 0; p < 10; p++) drive_pixel(p);
        do_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data[WIN_CENTRE] !== '0) begin
            bad++;
            $display("FAIL midreset_state: got valid=%0b ready=%0b centre=%0d, required 0 1 0", out_valid, in_ready, out_data[WIN_CENTRE]);
        end
        w0 = win_cnt;
        l0 = last_cnt;
        stream_frame(0, 0);
        settle();
        check_drained("midreset", w0, 4, l0, 1);
    endtask

    task automatic test_random();
        int w0, l0;
        do_reset();
        w0 = win_cnt;
        l0 = last_cnt;
        rnd_ready = 1;
        stream_frame(0, 1);
        stream_frame(200, 1);
        stream_frame(400, 1);
        settle();
        check_drained("random", w0, 12, l0, 3);
    endtask

    initial begin
        rstn      = 0;
        in_valid  = 0;
        in_data   = '0;
        out_ready = 1;
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
